draw_ball_render: RTL and testbench
===================================

DRAW_BALL_RENDER -- requirements
Module: draw_ball_render

Interface
- REQ-001 SHALL have parameter RADIUS, default 10, meaning ball radius in pixels.
- REQ-002 SHALL have parameter BALL_COLOR, default 12'hF_F_F, meaning RGB444 fill colour of the ball.
- REQ-003 SHALL use one clock, pclk; reset is synchronous and active-high, port name reset.
- REQ-004 pclk  input  1  pixel clock; all state updates on its rising edge.
- REQ-005 reset  input  1  synchronous active-high reset.
- REQ-006 x_pos  input  12  ball centre column from the horizontal motion generator.
- REQ-007 y_pos  input  12  ball centre row from the vertical motion generator.
- REQ-008 hcount_in  input  11  current pixel column, 0..1343.
- REQ-009 vcount_in  input  11  current pixel row, 0..805.
- REQ-010 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  VGA timing strobes.
- REQ-011 rgb_in  input  12  background pixel colour.
- REQ-012 hcount_out, vcount_out  output  11 each  hcount_in and vcount_in delayed.
- REQ-013 hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each  timing strobes delayed.
- REQ-014 rgb_out  output  12  pixel colour with the ball overlaid.

Function
- REQ-015 SHALL sample x_pos/y_pos into internal x_lat/y_lat only in the cycle where vblnk_in=1 and the registered previous vblnk_in=0 (frame-start edge).
- REQ-016 SHALL ignore x_pos/y_pos changes at all other times; the ball never tears within one active frame.
- REQ-017 If x_pos/y_pos change in the edge cycle, the values present in that cycle SHALL be latched.
- REQ-018 Stage 1 SHALL register dx=|hcount_in-x_lat| and dy=|vcount_in-y_lat|, computed as 13-bit signed differences before taking the magnitude (no wrap at screen edges), plus box = (dx<=RADIUS)&&(dy<=RADIUS).
- REQ-019 Stage 2 SHALL compute hit = box && (dx*dx+dy*dy <= RADIUS*RADIUS) && !hblnk && !vblnk, using the stage-1 delayed blanking signals and a sum width wide enough for 2*RADIUS^2 without overflow.
- REQ-020 rgb_out SHALL be BALL_COLOR when hit=1, otherwise rgb_in delayed by two cycles.
- REQ-021 All outputs SHALL have exactly 2-cycle latency from the corresponding inputs, mutually aligned.
- REQ-022 A ball partially off-screen (for example x_pos<RADIUS) SHALL draw only the visible part, with no wrapped pixels on the opposite edge.
- REQ-023 Pixels in blanking SHALL pass rgb_in unchanged even when geometrically inside the circle.

Reset
- REQ-024 While reset=1, all outputs SHALL be 0 on the next pclk edge; both pipeline stages and the previous-vblnk register SHALL be cleared.
- REQ-025 On reset, x_lat SHALL be 512 and y_lat SHALL be 384.
- REQ-026 Reset asserted mid-frame SHALL take effect on the next edge. After release, outputs SHALL become valid 2 cycles later, and latching SHALL resume at the next vblnk rising edge.

Structure
- REQ-027 The VGA timing constants (1024x768 active, 1344x806 total) and the RGB444 width SHALL live in a shared vga package used by the motion generators and renderers.
- REQ-028 The absolute-difference-and-square logic SHALL be a sub-module, ball_dist, instantiated once per axis. The timing delay line SHALL be inline.

Verification
- REQ-029 Reset: reset=1 for 3 cycles with nonzero inputs -> all outputs 0. After release, with x_lat/y_lat=512/384 and pixel (512,384) active -> rgb_out=FFF exactly 2 cycles later.
- REQ-030 Circle edge, x_lat=100, y_lat=100, rgb_in=000: pixel (110,100) -> FFF; (108,106) -> FFF, since 64+36=100; (108,107) -> 000, since 113>100; (111,100) -> 000.
- REQ-031 Frame latch: change x_pos from 100 to 300 at vcount=200 -> the remainder of the frame still draws at x=100. After the vblnk rising edge, the next frame draws at x=300.
- REQ-032 Edge clipping, x_pos=3, y_pos=400: pixel (0,400) -> FFF; (1340,400), in blanking -> rgb_in passthrough; no FFF at hcount 1014..1023.
- REQ-033 Alignment: random timing stream -> every output equals its input delayed by 2 cycles, except rgb on hit pixels.
- REQ-034 Mid-frame reset: reset pulsed at vcount=300 -> outputs 0 for that cycle. Ball reappears at 512/384 the next frame unless a new position is latched at the vblnk edge.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and types for the motion generators and renderers
package vga_pkg;
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam int H_TOTAL  = 1344;
    localparam int V_TOTAL  = 806;
    localparam int RGB_W    = 12;
    localparam int CNT_W    = 11;
    localparam int POS_W    = 12;

    localparam logic [POS_W-1:0] X_LAT_RST = 12'd512;
    localparam logic [POS_W-1:0] Y_LAT_RST = 12'd384;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_timing_t;

    // Distances beyond RADIUS never reach the squarer, so RADIUS+1 bounds the width.
    function automatic int dist_w(input int radius);
        return $clog2(radius + 2);
    endfunction
endpackage

// File: rtl/ball_dist.sv
// rtl/ball_dist.sv - per-axis registered |pixel-centre| with range flag and square
module ball_dist
    import vga_pkg::*;
#(
    parameter int RADIUS = 10,
    parameter int DW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  pix,
    input  logic [POS_W-1:0]  centre,
    output logic              in_range,
    output logic [2*DW-1:0]   dist_sq
);
    localparam logic [12:0] LIM = 13'(RADIUS);

    logic signed [12:0] diff;
    logic [12:0]        mag;
    logic [DW-1:0]      dist_d, dist_q;
    logic               in_range_d, in_range_q;

    // Signed 13-bit difference keeps an off-screen centre from wrapping to the far edge.
    always_comb begin
        diff       = $signed({2'b00, pix}) - $signed({1'b0, centre});
        mag        = diff[12] ? -diff : diff;
        in_range_d = (mag <= LIM);
        dist_d     = in_range_d ? mag[DW-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dist_q     <= '0;
            in_range_q <= 1'b0;
        end else begin
            dist_q     <= dist_d;
            in_range_q <= in_range_d;
        end
    end

    assign in_range = in_range_q;
    assign dist_sq  = {{DW{1'b0}}, dist_q} * {{DW{1'b0}}, dist_q};
endmodule

// File: rtl/draw_ball_render.sv
// rtl/draw_ball_render.sv - overlays a filled circle on the VGA stream with 2-cycle aligned latency
module draw_ball_render
    import vga_pkg::*;
#(
    parameter int               RADIUS     = 10,
    parameter logic [RGB_W-1:0] BALL_COLOR = 12'hFFF
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [POS_W-1:0]  x_pos,
    input  logic [POS_W-1:0]  y_pos,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic [CNT_W-1:0]  hcount_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);
    localparam int               DW    = dist_w(RADIUS);
    localparam int               SQ_W  = 2 * DW;
    localparam int               SUM_W = SQ_W + 1;
    localparam logic [SUM_W-1:0] R_SQ  = SUM_W'(RADIUS * RADIUS);

    vga_timing_t       tim_s1_d, tim_s1_q, tim_s2_d, tim_s2_q;
    logic [RGB_W-1:0]  rgb_s1_d, rgb_s1_q, rgb_s2_d, rgb_s2_q;
    logic [POS_W-1:0]  x_lat_d, x_lat_q, y_lat_d, y_lat_q;
    logic              vblnk_prev_d, vblnk_prev_q;
    logic              in_x, in_y, hit;
    logic [SQ_W-1:0]   dx_sq, dy_sq;
    logic [SUM_W-1:0]  dist_sum;

    ball_dist #(.RADIUS(RADIUS), .DW(DW)) u_dist_x (
        .clk(pclk), .reset(reset), .pix(hcount_in), .centre(x_lat_q),
        .in_range(in_x), .dist_sq(dx_sq)
    );

    ball_dist #(.RADIUS(RADIUS), .DW(DW)) u_dist_y (
        .clk(pclk), .reset(reset), .pix(vcount_in), .centre(y_lat_q),
        .in_range(in_y), .dist_sq(dy_sq)
    );

    always_comb begin
        vblnk_prev_d = vblnk_in;
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        // Position only moves at frame start so the ball never tears.
        if (vblnk_in && !vblnk_prev_q) begin
            x_lat_d = x_pos;
            y_lat_d = y_pos;
        end

        tim_s1_d.hcount = hcount_in;
        tim_s1_d.vcount = vcount_in;
        tim_s1_d.hsync  = hsync_in;
        tim_s1_d.vsync  = vsync_in;
        tim_s1_d.hblnk  = hblnk_in;
        tim_s1_d.vblnk  = vblnk_in;
        rgb_s1_d        = rgb_in;

        dist_sum = SUM_W'(dx_sq) + SUM_W'(dy_sq);
        hit      = in_x && in_y && (dist_sum <= R_SQ) && !tim_s1_q.hblnk && !tim_s1_q.vblnk;
        tim_s2_d = tim_s1_q;
        rgb_s2_d = hit ? BALL_COLOR : rgb_s1_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vblnk_prev_q <= 1'b0;
            x_lat_q      <= X_LAT_RST;
            y_lat_q      <= Y_LAT_RST;
            tim_s1_q     <= '0;
            rgb_s1_q     <= '0;
            tim_s2_q     <= '0;
            rgb_s2_q     <= '0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            tim_s1_q     <= tim_s1_d;
            rgb_s1_q     <= rgb_s1_d;
            tim_s2_q     <= tim_s2_d;
            rgb_s2_q     <= rgb_s2_d;
        end
    end

    assign hcount_out = tim_s2_q.hcount;
    assign vcount_out = tim_s2_q.vcount;
    assign hsync_out  = tim_s2_q.hsync;
    assign vsync_out  = tim_s2_q.vsync;
    assign hblnk_out  = tim_s2_q.hblnk;
    assign vblnk_out  = tim_s2_q.vblnk;
    assign rgb_out    = rgb_s2_q;
endmodule

// File: tb/tb_draw_ball_render.sv
// tb/tb_draw_ball_render.sv - directed and table-driven bench for draw_ball_render
module tb_draw_ball_render;
    localparam int R = 10;

    logic        pclk = 1'b0;
    logic        reset;
    logic [11:0] x_pos, y_pos;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_ball_render #(.RADIUS(R), .BALL_COLOR(12'hFFF)) dut (
        .pclk(pclk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    task automatic check_pixel(input string name, input int h, input int v, input logic hb,
                               input logic vb, input logic [11:0] rgb, input logic [11:0] exp);
        set_pix(h, v, hb, vb, rgb);
        tick();
        tick();
        check(name, {52'd0, rgb_out}, {52'd0, exp});
    endtask

    task automatic frame_edge(input int x, input int y);
        set_pix(1100, 780, 1'b1, 1'b0, 12'h000);
        tick();
        x_pos    = 12'(x);
        y_pos    = 12'(y);
        vblnk_in = 1'b1;
        tick();
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
    endtask

    function automatic logic model_hit(input pix_t p, input int xl, input int yl);
        int dx, dy;
        dx = int'(p.h) - xl;
        dy = int'(p.v) - yl;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx <= R) && (dy <= R) && (dx * dx + dy * dy <= R * R) && !p.hb && !p.vb;
    endfunction

    function automatic logic [37:0] out_word();
        return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    endfunction

    vec_t vecs[12];
    pix_t cur, prev;

    initial begin
        vecs[0]  = '{h: 110, v: 100, hb: 0, vb: 0, rgb: 12'h000, exp: 12'hFFF};
        vecs[1]  = '{h: 108, v: 106, hb: 0, vb: 0, rgb: 12'h000, exp: 12'hFFF};
        vecs[2]  = '{h: 108, v: 107, hb: 0, vb: 0, rgb: 12'h000, exp: 12'h000};
        vecs[3]  = '{h: 111, v: 100, hb: 0, vb: 0, rgb: 12'h000, exp: 12'h000};
        vecs[4]  = '{h: 100, v: 100, hb: 0, vb: 0, rgb: 12'h000, exp: 12'hFFF};
        vecs[5]  = '{h:  90, v: 100, hb: 0, vb: 0, rgb: 12'h000, exp: 12'hFFF};
        vecs[6]  = '{h:  89, v: 100, hb: 0, vb: 0, rgb: 12'h000, exp: 12'h000};
        vecs[7]  = '{h: 100, v:  90, hb: 0, vb: 0, rgb: 12'h000, exp: 12'hFFF};
        vecs[8]  = '{h: 100, v: 111, hb: 0, vb: 0, rgb: 12'h000, exp: 12'h000};
        vecs[9]  = '{h: 100, v: 100, hb: 1, vb: 0, rgb: 12'h5A5, exp: 12'h5A5};
        vecs[10] = '{h: 100, v: 100, hb: 0, vb: 1, rgb: 12'hA5A, exp: 12'hA5A};
        vecs[11] = '{h: 150, v: 100, hb: 0, vb: 0, rgb: 12'h0F0, exp: 12'h0F0};

        // Reset with busy inputs: outputs must be zero after every reset edge.
        x_pos = 12'd700;
        y_pos = 12'd500;
        set_pix(5, 7, 1'b1, 1'b0, 12'hABC);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_zero[%0d]", i), {26'd0, out_word()}, 64'd0);
        end

        set_pix(512, 384, 1'b0, 1'b0, 12'h123);
        reset = 1'b0;
        tick();
        check("post_reset_lat1", {52'd0, rgb_out}, 64'd0);
        tick();
        check("post_reset_centre", {52'd0, rgb_out}, 64'hFFF);
        check("post_reset_hcount", {53'd0, hcount_out}, 64'd512);

        // Circle boundary at centre (100,100).
        frame_edge(100, 100);
        for (int i = 0; i < 12; i++)
            check_pixel($sformatf("circle[%0d]", i), int'(vecs[i].h), int'(vecs[i].v),
                        vecs[i].hb, vecs[i].vb, vecs[i].rgb, vecs[i].exp);

        // Mid-frame position change is ignored until the next vblnk rising edge.
        set_pix(400, 200, 1'b0, 1'b0, 12'h000);
        x_pos = 12'd300;
        tick();
        check_pixel("latch_old_pos", 100, 100, 1'b0, 1'b0, 12'h000, 12'hFFF);
        check_pixel("latch_not_new", 300, 100, 1'b0, 1'b0, 12'h000, 12'h000);
        frame_edge(300, 100);
        check_pixel("latch_new_pos", 300, 100, 1'b0, 1'b0, 12'h000, 12'hFFF);
        check_pixel("latch_old_gone", 100, 100, 1'b0, 1'b0, 12'h000, 12'h000);

        // Left-edge clipping: no wrap onto the right side of the line.
        frame_edge(3, 400);
        check_pixel("clip_left", 0, 400, 1'b0, 1'b0, 12'h000, 12'hFFF);
        check_pixel("clip_r_in", 13, 400, 1'b0, 1'b0, 12'h000, 12'hFFF);
        check_pixel("clip_r_out", 14, 400, 1'b0, 1'b0, 12'h000, 12'h000);
        check_pixel("clip_blank", 1340, 400, 1'b1, 1'b0, 12'h321, 12'h321);
        for (int h = 1014; h <= 1023; h++)
            check_pixel($sformatf("clip_nowrap[%0d]", h), h, 400, 1'b0, 1'b0, 12'h000, 12'h000);

        // Random timing stream around the default centre: every output delayed by two.
        frame_edge(512, 384);
        for (int i = 0; i < 200; i++) begin
            cur.h   = 11'(500 + $urandom_range(0, 24));
            cur.v   = 11'(372 + $urandom_range(0, 24));
            cur.hs  = 1'($urandom_range(0, 1));
            cur.vs  = 1'($urandom_range(0, 1));
            cur.hb  = ($urandom_range(0, 3) == 0);
            cur.vb  = ($urandom_range(0, 5) == 0);
            cur.rgb = 12'($urandom_range(0, 4095));
            hcount_in = cur.h;
            vcount_in = cur.v;
            hsync_in  = cur.hs;
            vsync_in  = cur.vs;
            hblnk_in  = cur.hb;
            vblnk_in  = cur.vb;
            rgb_in    = cur.rgb;
            tick();
            if (i > 0)
                check($sformatf("align[%0d]", i), {26'd0, out_word()},
                      {26'd0, prev.h, prev.v, prev.hs, prev.vs, prev.hb, prev.vb,
                       (model_hit(prev, 512, 384) ? 12'hFFF : prev.rgb)});
            prev = cur;
        end

        // Mid-frame reset drops the latched position back to 512/384.
        frame_edge(100, 100);
        set_pix(100, 300, 1'b0, 1'b0, 12'hABC);
        hsync_in = 1'b1;
        reset    = 1'b1;
        tick();
        check("midreset_zero", {26'd0, out_word()}, 64'd0);
        reset = 1'b0;
        check_pixel("midreset_default", 512, 384, 1'b0, 1'b0, 12'h000, 12'hFFF);
        check_pixel("midreset_old_gone", 100, 100, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        frame_edge(100, 100);
        check_pixel("midreset_relatch", 100, 100, 1'b0, 1'b0, 12'h0F0, 12'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
